sn74151_scan_ctrl: RTL

Sequencer that drives the select (S2..S0) and enable (E, active-low) pins of an sn74151 8:1 multiplexer. It scans the eight data inputs in turn, samples the Z output after a programmable settle time, and assembles the results into an 8-bit word. A start/busy/done handshake frames each scan. The block sits between system logic and an sn74151 part, turning the mux into a parallel-in, sampled-word reader.

---
 rtl/sn74151_scan_ctrl_pkg.sv | 17 +
 rtl/sn74151_scan_ctrl_if.sv | 29 ++
 rtl/sn74151_scan_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/sn74151_scan_ctrl_pkg.sv
// sn74151_pkg
// Shared definitions for the sn74151 scan controller: the FSM state
// encoding and the widths of the channel select and settle counter.
// No ports; imported by the interface and the controller.
package sn74151_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sn74151_scan_ctrl_if.sv
// sn74151_scan_ctrl_if
// Bundles the host handshake (start/abort/chan_mask -> busy/done/data)
// and the mux-side pins (sel/en_n out, z in) of the scan controller.
//   master : system/bench side, drives start, abort, chan_mask and z
//   slave  : the controller, drives sel, en_n, busy, done and data
interface sn74151_scan_ctrl_if;
  import sn74151_pkg::*;

  logic              start;
  logic              abort;
  logic [NUM_CH-1:0] chan_mask;
  logic              z;
  logic [SEL_W-1:0]  sel;
  logic              en_n;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] data;

  modport master (
    output start, abort, chan_mask, z,
    input  sel, en_n, busy, done, data
  );

  modport slave (
    input  start, abort, chan_mask, z,
    output sel, en_n, busy, done, data
  );

endinterface

// File: rtl/sn74151_scan_ctrl.sv
// sn74151_scan_ctrl
// Steps an sn74151 8:1 mux through its eight inputs, holds each enabled
// channel for SETTLE extra cycles, samples Z and assembles an 8-bit word.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - slave side of sn74151_scan_ctrl_if (handshake + mux pins)
// Parameter:
//   SETTLE - extra cycles per enabled channel before sampling (0..15)
module sn74151_scan_ctrl
  import sn74151_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sn74151_scan_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);

  state_t            state, state_nx;
  logic [NUM_CH-1:0] mask_r, mask_nx;
  logic [NUM_CH-1:0] shadow, shadow_nx;
  logic [NUM_CH-1:0] data_r, data_nx;
  logic [SEL_W-1:0]  ch, ch_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic [SEL_W-1:0]  sel_q;
  logic              en_n_q;
  logic              busy_q;
  logic              done_q;

  // Next-state logic. A channel finishes when it is masked off or its
  // settle count has run out; abort overrides that, even on channel 7.
  // IDLE and DONE share the start path so back-to-back scans need no
  // extra idle cycle.
  always_comb begin
    state_nx  = state;
    mask_nx   = mask_r;
    shadow_nx = shadow;
    data_nx   = data_r;
    ch_nx     = ch;
    cnt_nx    = cnt;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nx  = SCAN;
          mask_nx   = bus.chan_mask;
          ch_nx     = '0;
          cnt_nx    = SETTLE_CNT;
          shadow_nx = '0;
        end else begin
          state_nx  = IDLE;
        end
      end

      SCAN: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (!mask_r[ch] || cnt == '0) begin
          shadow_nx[ch] = mask_r[ch] & bus.z;
          if (ch == LAST_CH) begin
            // The final bit goes into data on the same edge it is sampled.
            data_nx  = shadow_nx;
            state_nx = DONE;
          end else begin
            ch_nx  = ch + SEL_W'(1);
            cnt_nx = SETTLE_CNT;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // State and output registers. Outputs are decoded from the next state
  // so sel/en_n come straight from flops and cannot glitch on the mux.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mask_r <= '0;
      shadow <= '0;
      data_r <= '0;
      ch     <= '0;
      cnt    <= '0;
      sel_q  <= '0;
      en_n_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      mask_r <= mask_nx;
      shadow <= shadow_nx;
      data_r <= data_nx;
      ch     <= ch_nx;
      cnt    <= cnt_nx;
      sel_q  <= (state_nx == SCAN) ? ch_nx : '0;
      en_n_q <= (state_nx != SCAN);
      busy_q <= (state_nx == SCAN);
      done_q <= (state_nx == DONE);
    end
  end

  assign bus.sel  = sel_q;
  assign bus.en_n = en_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.data = data_r;

endmodule
